result_requantizer: RTL
=======================

RESULT_REQUANTIZER -- requirements
Module: result_requantizer

Interface
REQ-001 SHALL: parameter ACC_WIDTH, default 32, width of the accumulator input word.
REQ-002 SHALL: parameter DATA_WIDTH, default 16, width of the quantized output word.
REQ-003 SHALL: parameter ADDR_WIDTH, default 10, width of the result-memory address.
REQ-004 SHALL: parameter BIAS_DEPTH, default 64, number of per-column bias entries; index width is $clog2(BIAS_DEPTH).
REQ-005 SHALL: parameter FIFO_DEPTH, default 8, output FIFO entries (power of two).
REQ-006 SHALL: port list, one per line, name direction width meaning:
  clk  in  1  single clock, all logic on rising edge
  rst  in  1  asynchronous, active-high reset
  cfg_shift  in  5  arithmetic right-shift amount, 0..31
  cfg_relu  in  1  clamp negative results to zero
  cfg_cols  in  16  columns per row, 1..BIAS_DEPTH
  sat_clr  in  1  synchronous clear of sat_count
  bias_wr_en  in  1  bias table write strobe
  bias_wr_addr  in  $clog2(BIAS_DEPTH)  bias entry index
  bias_wr_data  in  DATA_WIDTH  signed bias value
  in_valid  in  1  accumulator word present
  in_ready  out  1  block accepts word this cycle
  in_addr  in  ADDR_WIDTH  result-memory address of word
  in_data  in  ACC_WIDTH  signed accumulator
  in_last  in  1  final word of matrix
  out_valid  out  1  quantized word present
  out_ready  in  1  consumer accepts word
  out_addr  out  ADDR_WIDTH  address, passed through unchanged
  out_data  out  DATA_WIDTH  signed quantized result
  out_last  out  1  final word of matrix
  busy  out  1  matrix in flight
  done  out  1  one-cycle completion pulse
  sat_count  out  16  saturation event counter

Function
REQ-007 SHALL: input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
REQ-008 SHALL: column counter starts at 0, increments per input transfer, wraps to 0 after cfg_cols-1, and resets to 0 on a transfer with in_last.
REQ-009 SHALL: stage 1 registers in_data + sign-extended bias[column], computed at ACC_WIDTH+1 bits, with cfg_shift, cfg_relu, in_addr and in_last carried alongside.
REQ-010 SHALL: stage 2 computes (sum + 2^(shift-1)) >>> shift when shift>0, and sum unchanged when shift=0, as round-half-up arithmetic shift at ACC_WIDTH+1 bits.
REQ-011 SHALL: stage 3 saturates to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], then applies ReLU (negative -> 0) if enabled, and writes the result to the FIFO.
REQ-012 SHALL: sat_count increments by 1 for each word whose value was clamped in stage 3, independent of ReLU, holds at 0xFFFF, and is cleared by sat_clr (sat_clr wins over a same-cycle increment).
REQ-013 SHALL: pipeline never stalls; latency from input transfer to out_valid is exactly 4 cycles when the FIFO is empty.
REQ-014 SHALL: in_ready is registered and high only when FIFO occupancy plus words in stages 1-3 is below FIFO_DEPTH after accounting for this cycle's transfers; no word is ever dropped.
REQ-015 SHALL: FIFO is show-ahead; out_data, out_addr and out_last are valid whenever out_valid is high; simultaneous push and pop at full or empty is legal and preserves occupancy.
REQ-016 SHALL: bias write takes effect for inputs transferred in later cycles; a same-cycle input uses the old value.
REQ-017 SHALL: busy sets on the first input transfer after idle and clears together with done.
REQ-018 SHALL: done pulses for exactly one cycle, the cycle after the out_last word transfers.
REQ-019 SHALL: order of words is preserved end to end.

Reset
REQ-020 SHALL: while rst is high, in_ready, out_valid, out_data, out_addr, out_last, busy, done and sat_count are 0; pipeline valids, FIFO pointers, column counter and all bias entries clear to 0.
REQ-021 SHALL: in_ready rises in the first clock after rst deasserts; reset mid-stream discards all in-flight words.

Verification
REQ-022 SHALL: bias=0, shift=0, in_data=100 -> out_data=100 with out_valid high 4 cycles after the input transfer.
REQ-023 SHALL: shift=4, in_data=24 -> out_data=2; in_data=-24 -> out_data=-1.
REQ-024 SHALL: shift=0, in_data=0x00100000 -> 0x7FFF, sat_count=1; in_data=0xFFF00000 -> 0x8000, sat_count=2; same input with relu=1 -> 0x0000, sat_count=3.
REQ-025 SHALL: cfg_cols=3, bias={10,20,30}, six zero inputs, in_last on the sixth -> outputs 10,20,30,10,20,30, then done one cycle after the last output transfer.
REQ-026 SHALL: out_ready=0 with 12 words offered -> in_ready low after 8 accepted; after out_ready=1, all 12 words are delivered in order.
REQ-027 SHALL: rst pulsed with 5 words in flight -> outputs 0, FIFO empty, and the next matrix starts at column 0 with bias 0.

Source files
------------

// File: rtl/result_requantizer.sv
// result_requantizer
//   Converts signed accumulator words into signed DATA_WIDTH results:
//   per-column bias add, round-half-up arithmetic right shift, saturation
//   and optional ReLU. Results pass through a show-ahead output FIFO.
//   The pipeline never stalls. in_ready is withheld early enough that the
//   FIFO can always absorb every word already inside the pipeline.
//
// Ports
//   clk, rst                    clock, asynchronous active-high reset
//   cfg_shift/cfg_relu/cfg_cols shift amount, ReLU enable, columns per row
//   sat_clr                     synchronous clear of sat_count
//   bias_wr_*                   bias table write port
//   in_*                        accumulator stream (valid/ready)
//   out_*                       quantized stream (valid/ready, show-ahead)
//   busy, done                  matrix-in-flight flag, one-cycle completion pulse
//   sat_count                   saturating count of clamped words
module result_requantizer #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 10,
    parameter int BIAS_DEPTH = 64,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4:0]                    cfg_shift,
    input  logic                          cfg_relu,
    input  logic [15:0]                   cfg_cols,
    input  logic                          sat_clr,
    input  logic                          bias_wr_en,
    input  logic [$clog2(BIAS_DEPTH)-1:0] bias_wr_addr,
    input  logic signed [DATA_WIDTH-1:0]  bias_wr_data,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [ADDR_WIDTH-1:0]         in_addr,
    input  logic signed [ACC_WIDTH-1:0]   in_data,
    input  logic                          in_last,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [ADDR_WIDTH-1:0]         out_addr,
    output logic signed [DATA_WIDTH-1:0]  out_data,
    output logic                          out_last,
    output logic                          busy,
    output logic                          done,
    output logic [15:0]                   sat_count
);
    localparam int BIW = $clog2(BIAS_DEPTH);
    localparam int SW  = ACC_WIDTH + 1;
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;
    localparam int TW  = PW + 3;
    localparam logic [SW-1:0] ONE_SW = {{(SW-1){1'b0}}, 1'b1};
    localparam logic signed [SW-1:0] SAT_MAX = $signed({{(SW-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}});
    localparam logic signed [SW-1:0] SAT_MIN = $signed({{(SW-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}});

    logic signed [DATA_WIDTH-1:0] r_bias [BIAS_DEPTH];
    logic [BIW-1:0]               r_col;
    // Stage registers
    logic                  r_s1_v, r_s1_relu, r_s1_last;
    logic signed [SW-1:0]  r_s1_sum;
    logic [4:0]            r_s1_shift;
    logic [ADDR_WIDTH-1:0] r_s1_addr;
    logic                  r_s2_v, r_s2_relu, r_s2_last;
    logic signed [SW-1:0]  r_s2_val;
    logic [ADDR_WIDTH-1:0] r_s2_addr;
    logic                  r_s3_v, r_s3_last;
    logic [DATA_WIDTH-1:0] r_s3_data;
    logic [ADDR_WIDTH-1:0] r_s3_addr;
    // FIFO storage and pointers
    logic [DATA_WIDTH-1:0] r_mem_data [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_mem_addr [FIFO_DEPTH];
    logic                  r_mem_last [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [CW-1:0]         r_count;
    // Registered outputs
    logic                  r_in_ready, r_out_valid, r_out_last, r_busy, r_done;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [ADDR_WIDTH-1:0] r_out_addr;
    logic [15:0]           r_sat_count;

    logic                  w_in_xfer, w_out_xfer, w_push, w_pop;
    logic signed [SW-1:0]  w_sum, w_rnd_sum, w_rnd;
    logic [SW-1:0]         w_rnd_inc;
    logic signed [DATA_WIDTH-1:0] w_bias;
    logic                  w_hi, w_lo, w_sat;
    logic [DATA_WIDTH-1:0] w_clamp, w_q;
    logic [CW-1:0]         w_count_n, w_after_pop;
    logic [PW-1:0]         w_rd_ptr_n;
    logic [TW-1:0]         w_total_n;
    logic [DATA_WIDTH-1:0] w_head_data;
    logic [ADDR_WIDTH-1:0] w_head_addr;
    logic                  w_head_last;

    assign w_in_xfer  = in_valid && r_in_ready;
    assign w_out_xfer = r_out_valid && out_ready;
    assign w_push     = r_s3_v;
    assign w_pop      = w_out_xfer;
    assign w_bias     = r_bias[r_col];
    assign w_sum      = $signed({in_data[ACC_WIDTH-1], in_data}) +
                        $signed({{(SW-DATA_WIDTH){w_bias[DATA_WIDTH-1]}}, w_bias});

    // Stage 2: round-half-up arithmetic right shift at SW bits
    always_comb begin
        w_rnd_inc = '0;
        w_rnd_sum = r_s1_sum;
        if (r_s1_shift != 5'd0) begin
            w_rnd_inc = ONE_SW << (r_s1_shift - 5'd1);
            w_rnd_sum = r_s1_sum + $signed(w_rnd_inc);
            w_rnd     = w_rnd_sum >>> r_s1_shift;
        end else begin
            w_rnd     = r_s1_sum;
        end
    end

    // Stage 3: saturate to DATA_WIDTH, then optional ReLU
    always_comb begin
        w_hi = (r_s2_val > SAT_MAX);
        w_lo = (r_s2_val < SAT_MIN);
        w_sat = w_hi || w_lo;
        if (w_hi) begin
            w_clamp = SAT_MAX[DATA_WIDTH-1:0];
        end else if (w_lo) begin
            w_clamp = SAT_MIN[DATA_WIDTH-1:0];
        end else begin
            w_clamp = r_s2_val[DATA_WIDTH-1:0];
        end
        if (r_s2_relu && w_clamp[DATA_WIDTH-1]) begin
            w_q = '0;
        end else begin
            w_q = w_clamp;
        end
    end

    // FIFO bookkeeping, next head word and admission control
    always_comb begin
        w_count_n   = r_count + CW'(w_push) - CW'(w_pop);
        w_after_pop = r_count - CW'(w_pop);
        if (w_pop) begin
            w_rd_ptr_n = r_rd_ptr + PW'(1);
        end else begin
            w_rd_ptr_n = r_rd_ptr;
        end
        // When the FIFO would be empty after the pop, the head is the word being pushed now
        if (w_after_pop == '0) begin
            w_head_data = r_s3_data;
            w_head_addr = r_s3_addr;
            w_head_last = r_s3_last;
        end else begin
            w_head_data = r_mem_data[w_rd_ptr_n];
            w_head_addr = r_mem_addr[w_rd_ptr_n];
            w_head_last = r_mem_last[w_rd_ptr_n];
        end
        // Next-cycle occupancy: FIFO plus the three stages as they will be after this edge
        w_total_n = TW'(w_count_n) + TW'(w_in_xfer) + TW'(r_s1_v) + TW'(r_s2_v);
    end

    // Bias table
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BIAS_DEPTH; i++) r_bias[i] <= '0;
        end else if (bias_wr_en) begin
            r_bias[bias_wr_addr] <= bias_wr_data;
        end
    end

    // FIFO storage (no reset needed: pointers define validity)
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= r_s3_data;
            r_mem_addr[r_wr_ptr] <= r_s3_addr;
            r_mem_last[r_wr_ptr] <= r_s3_last;
        end
    end

    // Pipeline, column counter, FIFO pointers, status and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_col <= '0;
            r_s1_v <= 1'b0; r_s1_relu <= 1'b0; r_s1_last <= 1'b0;
            r_s1_sum <= '0; r_s1_shift <= 5'd0; r_s1_addr <= '0;
            r_s2_v <= 1'b0; r_s2_relu <= 1'b0; r_s2_last <= 1'b0;
            r_s2_val <= '0; r_s2_addr <= '0;
            r_s3_v <= 1'b0; r_s3_last <= 1'b0; r_s3_data <= '0; r_s3_addr <= '0;
            r_wr_ptr <= '0; r_rd_ptr <= '0; r_count <= '0;
            r_in_ready <= 1'b0; r_out_valid <= 1'b0; r_out_last <= 1'b0;
            r_out_data <= '0; r_out_addr <= '0;
            r_busy <= 1'b0; r_done <= 1'b0; r_sat_count <= 16'd0;
        end else begin
            if (w_in_xfer) begin
                if (in_last || (16'(r_col) == cfg_cols - 16'd1)) begin
                    r_col <= '0;
                end else begin
                    r_col <= r_col + BIW'(1);
                end
            end
            r_s1_v     <= w_in_xfer;
            r_s1_sum   <= w_sum;
            r_s1_shift <= cfg_shift;
            r_s1_relu  <= cfg_relu;
            r_s1_addr  <= in_addr;
            r_s1_last  <= in_last;
            r_s2_v     <= r_s1_v;
            r_s2_val   <= w_rnd;
            r_s2_relu  <= r_s1_relu;
            r_s2_addr  <= r_s1_addr;
            r_s2_last  <= r_s1_last;
            r_s3_v     <= r_s2_v;
            r_s3_data  <= w_q;
            r_s3_addr  <= r_s2_addr;
            r_s3_last  <= r_s2_last;
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            r_rd_ptr    <= w_rd_ptr_n;
            r_count     <= w_count_n;
            r_out_valid <= (w_count_n != '0);
            r_out_data  <= w_head_data;
            r_out_addr  <= w_head_addr;
            r_out_last  <= w_head_last;
            r_in_ready  <= (w_total_n < TW'(FIFO_DEPTH));
            if (sat_clr) begin
                r_sat_count <= 16'd0;
            end else if (r_s2_v && w_sat && (r_sat_count != 16'hFFFF)) begin
                r_sat_count <= r_sat_count + 16'd1;
            end
            if (w_in_xfer) begin
                r_busy <= 1'b1;
            end else if (w_out_xfer && r_out_last) begin
                r_busy <= 1'b0;
            end
            r_done <= w_out_xfer && r_out_last;
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_data;
    assign out_addr  = r_out_addr;
    assign out_last  = r_out_last;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sat_count = r_sat_count;
endmodule
